// File: rtl/bf16_pkg.sv
// Shared bfloat16 field positions, operand-triple type and feeder state encoding.
package bf16_pkg;

  localparam int BF16_W = 16;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 7;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  typedef struct packed {
    logic [BF16_W-1:0] a;
    logic [BF16_W-1:0] b;
    logic [BF16_W-1:0] c;
  } bf16_triple_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feed_state_t;

  // An all-ones exponent marks Inf or NaN regardless of the mantissa.
  function automatic logic is_inf_nan(input logic [BF16_W-1:0] x);
    return x[EXP_MSB:EXP_LSB] == EXP_ALL1;
  endfunction

endpackage

// File: rtl/bf16_operand_feeder_if.sv
// Operand-feeder bus: upstream push port, run control, and the issue port toward the FMA.
interface bf16_operand_feeder_if
  import bf16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  // Both streams use strict valid/ready: a transfer happens on a rising edge where
  // valid && ready; a source holding valid keeps its payload stable until that edge.
  logic                     in_valid;
  logic                     in_ready;
  logic [BF16_W-1:0]        in_a;
  logic [BF16_W-1:0]        in_b;
  logic [BF16_W-1:0]        in_c;
  logic                     start;
  logic [CNT_W-1:0]         num;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic [BF16_W-1:0]        out_a;
  logic [BF16_W-1:0]        out_b;
  logic [BF16_W-1:0]        out_c;
  logic                     out_special;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         issued;
  feed_state_t              state_dbg;

  modport slave (
    input  in_valid, in_a, in_b, in_c, start, num, out_ready,
    output in_ready, busy, done, out_valid, out_a, out_b, out_c, out_special,
           level, issued, state_dbg
  );

  modport master (
    output in_valid, in_a, in_b, in_c, start, num, out_ready,
    input  in_ready, busy, done, out_valid, out_a, out_b, out_c, out_special,
           level, issued, state_dbg
  );

endinterface

// File: rtl/bf16_triple_fifo.sv
// Operand-triple FIFO: power-of-two depth, occupancy counter, no bypass path.
module bf16_triple_fifo
  import bf16_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  bf16_triple_t           wdata_i,
  input  logic                   pop_i,
  output bf16_triple_t           rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  bf16_triple_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bf16_operand_feeder.sv
// Streams a programmed number of buffered {A,B,C} triples into the bf16 FMA.
// Optional Inf/NaN head flag is enabled by defining BF16_FEED_SCREEN_EN.
module bf16_operand_feeder
  import bf16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bf16_operand_feeder_if.slave  bus
);

  feed_state_t      state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] issued_q;
  logic             done_q;
  logic             busy_q;

  bf16_triple_t     wdata;
  bf16_triple_t     head;
  logic             full, empty;
  logic             do_push, do_pop;
  logic             out_valid;

  assign wdata     = '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
  assign do_push   = bus.in_valid && !full;
  assign out_valid = (state_q == RUN) && !empty && (issued_q != num_q);
  assign do_pop    = out_valid && bus.out_ready;

  bf16_triple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (do_push),
    .wdata_i (wdata),
    .pop_i   (do_pop),
    .rdata_o (head),
    .level_o (bus.level),
    .full_o  (full),
    .empty_o (empty)
  );

  // done and busy are registered alongside the state so they change only on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            num_q    <= bus.num;
            issued_q <= '0;
            busy_q   <= 1'b1;
            if (bus.num == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (do_pop) begin
            issued_q <= issued_q + 1'b1;
            if (CNT_W'(issued_q + 1'b1) == num_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid;
  assign bus.out_a     = head.a;
  assign bus.out_b     = head.b;
  assign bus.out_c     = head.c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.issued    = issued_q;
  assign bus.state_dbg = state_q;

`ifdef BF16_FEED_SCREEN_EN
  assign bus.out_special = out_valid &&
                           (is_inf_nan(head.a) || is_inf_nan(head.b) || is_inf_nan(head.c));
`else
  assign bus.out_special = 1'b0;
`endif

endmodule

// File: tb/tb_bf16_operand_feeder.sv
// Directed bench for bf16_operand_feeder with a queue-based scoreboard on the issue port.
module tb_bf16_operand_feeder;
  import bf16_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef BF16_FEED_SCREEN_EN
  localparam logic SPECIAL_EXP = 1'b1;
`else
  localparam logic SPECIAL_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   model_cnt;
  int   done_seen;
  logic [47:0] exp_q[$];

  bf16_operand_feeder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  bf16_operand_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.done) done_seen++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue act=%h_%h_%h exp=none", bus.out_a, bus.out_b, bus.out_c);
      end else begin
        check("issue_data", {bus.out_a, bus.out_b, bus.out_c}, exp_q.pop_front());
        model_cnt--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic accept;
    accept = (model_cnt < DEPTH);
    check("in_ready", bus.in_ready, accept);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    @(posedge clk);
    if (accept) begin
      exp_q.push_back({a, b, c});
      model_cnt++;
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    bus.num = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.num = 8'hA5;
  endtask

  task automatic wait_done(input string name, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_issued"}, bus.issued, 0);
    check({tag, "_special"}, bus.out_special, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    checks = 0;
    failures = 0;
    model_cnt = 0;
    done_seen = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.start = 1'b0;
    bus.num = '0;
    bus.out_ready = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    check_reset_outputs("reset");

    // Two-triple run, consumer always ready.
    bus.out_ready = 1'b1;
    push(16'h3F80, 16'h4000, 16'h3F80);
    push(16'h4040, 16'h4040, 16'h0000);
    check("t1_level_pre", bus.level, 2);
    d0 = done_seen;
    start_run(8'd2);
    check("t1_out_valid_first", bus.out_valid, 1'b1);
    check("t1_busy", bus.busy, 1'b1);
    idle_cycles(1);
    check("t1_issued_1", bus.issued, 1);
    idle_cycles(1);
    check("t1_done", bus.done, 1'b1);
    check("t1_issued_2", bus.issued, 2);
    check("t1_level_post", bus.level, 0);
    check("t1_out_valid_off", bus.out_valid, 1'b0);
    idle_cycles(1);
    check("t1_done_pulse", bus.done, 1'b0);
    check("t1_idle", bus.busy, 1'b0);
    check("t1_done_count", done_seen - d0, 1);

    // Overfill with no run: ninth triple must be refused.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      push(16'h4100 + 16'(i), 16'h4200 + 16'(i), 16'h4300 + 16'(i));
    check("t2_level_full", bus.level, DEPTH);
    check("t2_in_ready_full", bus.in_ready, 1'b0);
    check("t2_out_valid_idle", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    start_run(8'd8);
    wait_done("t2_done", 20);
    check("t2_issued", bus.issued, 8);
    check("t2_level_empty", bus.level, 0);
    idle_cycles(1);

    // Underflow stall: run of 3 with 1 queued.
    push(16'h3F00, 16'h3E80, 16'hBF80);
    d0 = done_seen;
    start_run(8'd3);
    idle_cycles(4);
    check("t3_stall_issued", bus.issued, 1);
    check("t3_stall_busy", bus.busy, 1'b1);
    check("t3_stall_valid", bus.out_valid, 1'b0);
    push(16'h4080, 16'h40A0, 16'h40C0);
    idle_cycles(2);
    check("t3_no_early_done", done_seen - d0, 0);
    push(16'h40E0, 16'h4100, 16'h4110);
    wait_done("t3_done", 10);
    check("t3_issued", bus.issued, 3);
    idle_cycles(1);

    // Backpressure: payload held stable while out_ready is low.
    bus.out_ready = 1'b0;
    push(16'h1234, 16'h5678, 16'h9ABC);
    start_run(8'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", bus.out_valid, 1'b1);
      check("t4_hold_data", {bus.out_a, bus.out_b, bus.out_c}, 48'h1234_5678_9ABC);
      idle_cycles(1);
    end
    bus.out_ready = 1'b1;
    wait_done("t4_done", 5);
    check("t4_issued", bus.issued, 1);
    idle_cycles(1);

    // Zero-length run.
    d0 = done_seen;
    start_run(8'd0);
    check("t5_zero_done", bus.done, 1'b1);
    check("t5_zero_issued", bus.issued, 0);
    idle_cycles(1);
    check("t5_zero_done_off", bus.done, 1'b0);
    check("t5_zero_busy_off", bus.busy, 1'b0);
    check("t5_zero_done_count", done_seen - d0, 1);

    // Head screening flag.
    bus.out_ready = 1'b0;
    push(16'h7F80, 16'h3F80, 16'h0000);
    push(16'h3F80, 16'h3F80, 16'h3F80);
    start_run(8'd2);
    check("t6_special_inf", bus.out_special, SPECIAL_EXP);
    bus.out_ready = 1'b1;
    idle_cycles(1);
    check("t6_valid_second", bus.out_valid, 1'b1);
    check("t6_special_normal", bus.out_special, 1'b0);
    wait_done("t6_done", 5);
    idle_cycles(1);

    // Reset in the middle of a run.
    bus.out_ready = 1'b0;
    push(16'h4000, 16'h4000, 16'h4000);
    push(16'h7FC0, 16'h4000, 16'h4000);
    start_run(8'd5);
    check("t7_busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    idle_cycles(1);
    rst = 1'b0;
    check_reset_outputs("t7_rst");
    idle_cycles(2);
    check("t7_stays_idle", bus.busy, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
